fetch_queue: RTL



---
 rtl/fetch_queue.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, keeps at most one imem request in flight,
// and buffers returned words with their PCs in a DEPTH-entry prefetch FIFO toward decode.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [63:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_data,
    input  logic                     redirect,
    input  logic [63:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [63:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   drop_addr_q, drop_addr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [63:0]   pc_mem_q    [DEPTH];

    logic          push_s;
    logic          pop_s;
    logic          not_empty_s;
    logic [CW-1:0] cnt_after_push_s;
    logic [63:0]   redirect_target_s;

    assign not_empty_s       = (count_q != CNT_ZERO);
    assign pop_s             = not_empty_s & out_ready;
    assign redirect_target_s = redirect_pc & ~64'd3;
    assign cnt_after_push_s  = count_q + CNT_ONE - (pop_s ? CNT_ONE : CNT_ZERO);

    // Fetch FSM, FIFO bookkeeping and fetch-PC update; redirect overrides push and pop.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        push_s      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!redirect && (count_q < FULL_C)) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    if (imem_ack) begin
                        state_d = S_IDLE;
                    end else begin
                        // Request must stay on the bus until the memory answers it.
                        state_d     = S_DROP;
                        drop_addr_d = fetch_pc_q;
                    end
                end else if (imem_ack) begin
                    push_s     = 1'b1;
                    fetch_pc_d = fetch_pc_q + 64'd4;
                    state_d    = (cnt_after_push_s < FULL_C) ? S_WAIT : S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DROP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (redirect) begin
            fetch_pc_d = redirect_target_s;
            wr_ptr_d   = PTR_ZERO;
            rd_ptr_d   = PTR_ZERO;
            count_d    = CNT_ZERO;
        end else begin
            wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
            count_d  = count_q + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            count_q     <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; entries are only observed while count says they are occupied.
    always_ff @(posedge clk) begin
        if (push_s) begin
            instr_mem_q[wr_ptr_q] <= imem_data;
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
        end
    end

    assign imem_req  = (state_q == S_WAIT) || (state_q == S_DROP);
    assign imem_addr = (state_q == S_DROP) ? drop_addr_q : fetch_pc_q;
    assign out_valid = not_empty_s;
    assign out_instr = not_empty_s ? instr_mem_q[rd_ptr_q] : 32'd0;
    assign out_pc    = not_empty_s ? pc_mem_q[rd_ptr_q] : 64'd0;
    assign count     = count_q;

endmodule
